// File: rtl/rv_isa_pkg.sv
// rv_isa_pkg: RISC-V immediate-format codes, opcode/funct3 constants and
// per-format immediate bounds shared by the encode and decode sides.
package rv_isa_pkg;

   typedef enum logic [2:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_J = 3'b011,
      IMM_U = 3'b100,
      IMM_R = 3'b101
   } imm_src_e;

   localparam logic [6:0] OPC_LOAD = 7'b0000011;
   localparam logic [6:0] OPC_STOR = 7'b0100011;

   localparam logic [2:0] F3_SLLI = 3'b001;
   localparam logic [2:0] F3_SRxI = 3'b101;

   localparam int SH_MIN = 0;
   localparam int SH_MAX = 31;
   localparam int I_MIN  = -2048;
   localparam int I_MAX  = 2047;
   localparam int S_MIN  = -2048;
   localparam int S_MAX  = 2047;
   localparam int B_MIN  = -4096;
   localparam int B_MAX  = 4094;
   localparam int J_MIN  = -1048576;
   localparam int J_MAX  = 1048574;

   // One instruction's worth of fields as it travels through stage 1
   typedef struct packed {
      logic [2:0]  imm_src;
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [31:0] imm;
   } enc_fields_t;

   // Signed range test of a 32-bit immediate
   function automatic logic in_range(input logic [31:0] v, input int lo, input int hi);
      return ($signed(v) >= lo) && ($signed(v) <= hi);
   endfunction

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// imm_pack: combinational packer mapping the stage-1 fields to an
// instruction word and a representability error flag.
// Error logic is only built when ENC_RANGE_CHECK_EN is defined.
module imm_pack
   import rv_isa_pkg::*;
(
   input  enc_fields_t f,
   output logic [31:0] instr,
   output logic        err
);

   logic is_shift;

   // An I-format ALU op with a shift funct3 carries a 5-bit shamt plus funct7
   assign is_shift = (f.imm_src == IMM_I) &&
                     (f.opcode != OPC_LOAD) && (f.opcode != OPC_STOR) &&
                     ((f.funct3 == F3_SLLI) || (f.funct3 == F3_SRxI));

   // Scatter the immediate into the bit positions of the selected format
   always_comb begin
      instr = '0;
      case (f.imm_src)
         IMM_I: begin
            if (is_shift)
               instr = {f.funct7, f.imm[4:0], f.rs1, f.funct3, f.rd, f.opcode};
            else
               instr = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
         end
         IMM_S: instr = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
         IMM_B: instr = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                         f.imm[4:1], f.imm[11], f.opcode};
         IMM_J: instr = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.opcode};
         IMM_U: instr = {f.imm[31:12], f.rd, f.opcode};
         IMM_R: instr = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
         default: instr = '0;
      endcase
   end

`ifdef ENC_RANGE_CHECK_EN
   // Flag immediates the format cannot hold exactly, and unknown formats
   always_comb begin
      err = 1'b0;
      case (f.imm_src)
         IMM_I: begin
            if (is_shift)
               err = !in_range(f.imm, SH_MIN, SH_MAX);
            else
               err = !in_range(f.imm, I_MIN, I_MAX);
         end
         IMM_S: err = !in_range(f.imm, S_MIN, S_MAX);
         IMM_B: err = !in_range(f.imm, B_MIN, B_MAX) || f.imm[0];
         IMM_J: err = !in_range(f.imm, J_MIN, J_MAX) || f.imm[0];
         IMM_U: err = |f.imm[11:0];
         IMM_R: err = 1'b0;
         default: err = 1'b1;
      endcase
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: two-stage RISC-V instruction encoder with a sequential
// write address for streaming programs into instruction memory.
// ENC_RANGE_CHECK_EN enables out_err and the saturating err_cnt.
module instr_encoder
   import rv_isa_pkg::*;
#(
   parameter int            AW        = 32,
   parameter logic [AW-1:0] BASE_ADDR = '0
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [2:0]    in_imm_src,
   input  logic [6:0]    in_opcode,
   input  logic [4:0]    in_rd,
   input  logic [4:0]    in_rs1,
   input  logic [4:0]    in_rs2,
   input  logic [2:0]    in_funct3,
   input  logic [6:0]    in_funct7,
   input  logic [31:0]   in_imm,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   out_instr,
   output logic [AW-1:0] out_addr,
   output logic          out_err,
   output logic [7:0]    err_cnt
);

   enc_fields_t   in_fields;
   enc_fields_t   s1_fields;
   logic          s1_valid;
   logic          s1_advance;
   logic          handshake;
   logic [31:0]   pack_instr;
   logic          pack_err;
   logic          s2_valid;
   logic [31:0]   s2_instr;
   logic          s2_err;
   logic [AW-1:0] addr;

   assign in_fields = '{imm_src: in_imm_src, opcode: in_opcode, rd: in_rd,
                        rs1: in_rs1, rs2: in_rs2, funct3: in_funct3,
                        funct7: in_funct7, imm: in_imm};

   assign handshake  = s2_valid && out_ready;
   assign s1_advance = !s2_valid || out_ready;
   assign in_ready   = !s1_valid || s1_advance;

   imm_pack u_pack (
      .f     (s1_fields),
      .instr (pack_instr),
      .err   (pack_err)
   );

   // Stage 1: capture the field bundle whenever it can move on or is empty
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_fields <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid)
            s1_fields <= in_fields;
      end
   end

   // Stage 2: hold the packed word until the consumer takes it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_instr <= '0;
         s2_err   <= 1'b0;
      end else if (s1_advance) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_instr <= pack_instr;
            s2_err   <= pack_err;
         end
      end
   end

   // Write address steps one word per accepted output, wrapping naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         addr <= BASE_ADDR;
      else if (handshake)
         addr <= addr + AW'(4);
   end

`ifdef ENC_RANGE_CHECK_EN
   logic [7:0] cnt;

   // Count emitted error words, sticking at 255
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (handshake && s2_err && (cnt != 8'hFF))
         cnt <= cnt + 8'd1;
   end

   assign err_cnt = cnt;
`else
   assign err_cnt = 8'd0;
`endif

   assign out_valid = s2_valid;
   assign out_instr = s2_instr;
   assign out_err   = s2_err;
   assign out_addr  = addr;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: table-driven directed vectors for instr_encoder plus
// hand-written backpressure, reset and error-count saturation sequences.
// Expected errors follow ENC_RANGE_CHECK_EN.
module tb_instr_encoder;

`ifdef ENC_RANGE_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   typedef struct {
      logic [2:0]  src;
      logic [6:0]  opc;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      logic [31:0] exp_instr;
      logic        exp_err;
   } vec_t;

   localparam int NV = 17;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_imm_src;
   logic [6:0]  in_opcode;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [2:0]  in_funct3;
   logic [6:0]  in_funct7;
   logic [31:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_addr;
   logic        out_err;
   logic [7:0]  err_cnt;

   vec_t vecs [NV];
   int   n_checks;
   int   n_miss;

   instr_encoder #(.AW(32), .BASE_ADDR(32'h0)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_imm_src (in_imm_src),
      .in_opcode  (in_opcode),
      .in_rd      (in_rd),
      .in_rs1     (in_rs1),
      .in_rs2     (in_rs2),
      .in_funct3  (in_funct3),
      .in_funct7  (in_funct7),
      .in_imm     (in_imm),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_instr  (out_instr),
      .out_addr   (out_addr),
      .out_err    (out_err),
      .err_cnt    (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   function automatic vec_t mk(input logic [2:0] src, input logic [6:0] opc,
                               input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [31:0] imm,
                               input logic [31:0] exp_instr, input logic exp_err);
      vec_t v;
      v.src = src; v.opc = opc; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
      v.f3 = f3; v.f7 = f7; v.imm = imm;
      v.exp_instr = exp_instr;
      v.exp_err = exp_err & CHK;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_miss++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      in_imm_src = v.src;
      in_opcode  = v.opc;
      in_rd      = v.rd;
      in_rs1     = v.rs1;
      in_rs2     = v.rs2;
      in_funct3  = v.f3;
      in_funct7  = v.f7;
      in_imm     = v.imm;
   endtask

   // Hold a bundle valid until it is accepted; returns at posedge+1 of the accepting edge
   task automatic push(input vec_t v, output bit ok);
      applyStimulus(v);
      in_valid = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
         #1;
         if (in_ready) ok = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      #1 rst_n = 1'b0;
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] exp_addr;
      int          exp_cnt;
      int          acc_n;
      int          idx;
      int          got;
      bit          ok;
      bit          acc;

      n_checks = 0;
      n_miss   = 0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      applyStimulus(mk(3'b000, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'd0, 1'b0));

      vecs[0]  = mk(3'b000, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,  32'd5,        32'h00500093, 1'b0);
      vecs[1]  = mk(3'b010, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0,  32'hFFFFFFF8, 32'hFE208CE3, 1'b0);
      vecs[2]  = mk(3'b100, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0,  32'h12345000, 32'h123452B7, 1'b0);
      vecs[3]  = mk(3'b000, 7'b0010011, 5'd3, 5'd3, 5'd0, 3'd1, 7'd0,  32'd4,        32'h00419193, 1'b0);
      vecs[4]  = mk(3'b011, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,  32'd3,        32'h002000EF, 1'b1);
      vecs[5]  = mk(3'b001, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0,  32'hFFFFF800, 32'h8020A023, 1'b0);
      vecs[6]  = mk(3'b000, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,  32'd2048,     32'h80000093, 1'b1);
      vecs[7]  = mk(3'b000, 7'b0010011, 5'd3, 5'd3, 5'd0, 3'd1, 7'd0,  32'd32,       32'h00019193, 1'b1);
      vecs[8]  = mk(3'b000, 7'b0000011, 5'd1, 5'd2, 5'd0, 3'd1, 7'd0,  32'hFFFFFFFF, 32'hFFF11083, 1'b0);
      vecs[9]  = mk(3'b101, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0,  32'hDEADBEEF, 32'h002081B3, 1'b0);
      vecs[10] = mk(3'b110, 7'b0010011, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0,  32'd0,        32'h00000000, 1'b1);
      vecs[11] = mk(3'b010, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd1, 7'd0,  32'd4094,     32'h7E001FE3, 1'b0);
      vecs[12] = mk(3'b010, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd1, 7'd0,  32'd4096,     32'h80001063, 1'b1);
      vecs[13] = mk(3'b100, 7'b0110111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,  32'h00001001, 32'h000010B7, 1'b1);
      vecs[14] = mk(3'b011, 7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,  32'hFFF00000, 32'h8000006F, 1'b0);
      vecs[15] = mk(3'b111, 7'b1101111, 5'd5, 5'd5, 5'd5, 3'd7, 7'h7F, 32'hFFFFFFFF, 32'h00000000, 1'b1);
      vecs[16] = mk(3'b000, 7'b0010011, 5'd1, 5'd1, 5'd0, 3'd5, 7'h20, 32'd31,       32'h41F0D093, 1'b0);

      // Reset values while reset is held
      #12;
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_instr", out_instr, 32'd0);
      checkOutput("rst_out_err",   32'(out_err),   32'd0);
      checkOutput("rst_err_cnt",   32'(err_cnt),   32'd0);
      checkOutput("rst_out_addr",  out_addr,       32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("rst_in_ready",  32'(in_ready),  32'd1);

      // Table: one bundle at a time with the consumer always ready
      exp_addr  = 32'd0;
      exp_cnt   = 0;
      out_ready = 1'b1;
      for (int i = 0; i < NV; i++) begin
         push(vecs[i], ok);
         checkOutput($sformatf("v%0d_accept", i), 32'(ok), 32'd1);
         checkOutput($sformatf("v%0d_valid_early", i), 32'(out_valid), 32'd0);
         @(posedge clk); #1;
         checkOutput($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
         checkOutput($sformatf("v%0d_instr", i), out_instr, vecs[i].exp_instr);
         checkOutput($sformatf("v%0d_err", i),   32'(out_err), 32'(vecs[i].exp_err));
         checkOutput($sformatf("v%0d_addr", i),  out_addr, exp_addr);
         @(posedge clk); #1;
         exp_addr = exp_addr + 32'd4;
         if (vecs[i].exp_err && exp_cnt < 255) exp_cnt++;
         checkOutput($sformatf("v%0d_err_cnt", i), 32'(err_cnt), 32'(exp_cnt));
      end

      // Full-rate stream of invalid formats drives err_cnt into saturation
      applyStimulus(vecs[15]);
      in_valid = 1'b1;
      acc_n = 0;
      for (int c = 0; c < 260; c++) begin
         #1;
         if (in_ready) acc_n++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      exp_cnt = CHK ? ((exp_cnt + acc_n > 255) ? 255 : exp_cnt + acc_n) : 0;
      exp_addr = exp_addr + 32'(4 * acc_n);
      checkOutput("sat_accepts", 32'(acc_n), 32'd260);
      checkOutput("sat_err_cnt", 32'(err_cnt), 32'(exp_cnt));
      checkOutput("sat_addr", out_addr, exp_addr);
      checkOutput("sat_drained", 32'(out_valid), 32'd0);

      // Backpressure: only two bundles fit while the consumer stalls
      do_reset();
      out_ready = 1'b0;
      idx = 0;
      for (int c = 0; c < 6; c++) begin
         if (idx < 4) begin
            applyStimulus(vecs[idx]);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         acc = in_ready;
         @(posedge clk); #1;
         if (acc && idx < 4) idx++;
      end
      in_valid = 1'b0;
      checkOutput("bp_accepts",  32'(idx), 32'd2);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_hold_instr", out_instr, vecs[0].exp_instr);
      checkOutput("bp_hold_addr",  out_addr, 32'd0);

      out_ready = 1'b1;
      exp_addr = 32'd0;
      got = 0;
      for (int c = 0; c < 20 && got < 4; c++) begin
         if (idx < 4) begin
            applyStimulus(vecs[idx]);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         acc = in_ready;
         if (out_valid) begin
            checkOutput($sformatf("bp_w%0d_instr", got), out_instr, vecs[got].exp_instr);
            checkOutput($sformatf("bp_w%0d_addr", got),  out_addr, exp_addr);
            got++;
            exp_addr = exp_addr + 32'd4;
         end
         @(posedge clk); #1;
         if (acc && idx < 4) idx++;
      end
      in_valid = 1'b0;
      checkOutput("bp_drained", 32'(got), 32'd4);
      checkOutput("bp_no_dup", 32'(out_valid), 32'd0);
      checkOutput("bp_err_cnt", 32'(err_cnt), 32'd0);

      // Reset with both stages full discards them and restarts the address
      out_ready = 1'b0;
      applyStimulus(vecs[0]);
      in_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      in_valid = 1'b0;
      checkOutput("mid_full_valid", 32'(out_valid), 32'd1);
      checkOutput("mid_full_in_ready", 32'(in_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
      checkOutput("mid_rst_addr",  out_addr, 32'd0);
      checkOutput("mid_rst_instr", out_instr, 32'd0);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b1;
      checkOutput("mid_no_stale", 32'(out_valid), 32'd0);
      push(vecs[2], ok);
      checkOutput("mid_accept", 32'(ok), 32'd1);
      @(posedge clk); #1;
      checkOutput("mid_valid", 32'(out_valid), 32'd1);
      checkOutput("mid_instr", out_instr, vecs[2].exp_instr);
      checkOutput("mid_addr",  out_addr, 32'd0);
      @(posedge clk); #1;
      checkOutput("mid_after_valid", 32'(out_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
      $finish;
   end

endmodule
